// File: rtl/uart_bridge_pkg.sv
// Shared command codes, response code and FSM state encoding for the UART bus
// bridge responder.
package uart_bridge_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RESP_ACK  = 8'h06;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    BUS_REQ,
    RD_WAIT,
    TX_RESP,
    TX_GUARD,
    TX_WAIT
  } state_t;

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_WRITE) || (b == CMD_READ);
  endfunction

endpackage

// File: rtl/uart_rx_fetch.sv
// Byte fetch from the UART receiver: consumes a pending byte when enabled and
// blanks rx_ready for one cycle after each clear while the receiver drops it.
module uart_rx_fetch (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_en,
  input  logic       i_rx_ready,
  input  logic [7:0] i_rx_data,
  output logic       o_rx_ready_clr,
  output logic       o_byte_valid,
  output logic [7:0] o_byte
);

  logic r_guard;
  logic w_take;

  assign w_take         = i_rstn && i_en && i_rx_ready && !r_guard;
  assign o_rx_ready_clr = w_take;
  assign o_byte_valid   = w_take;
  assign o_byte         = i_rx_data;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) r_guard <= 1'b0;
    else         r_guard <= w_take;
  end

endmodule

// File: rtl/uart_bridge_responder.sv
// Far-end UART bus bridge: parses write/read command frames into single-beat
// bus requests and answers with one byte. Optional inter-byte timeout under
// macro UART_BRIDGE_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | waiting for a command byte (0x57 write / 0x52 read)
// ADDR     | shifting in address bytes, MSB first
// DATA     | waiting for the write data byte
// BUS_REQ  | m_valid high until m_ready
// RD_WAIT  | waiting for m_rvalid
// TX_RESP  | waiting for the transmitter to go idle, then pulse tx_en
// TX_GUARD | one cycle for the transmitter to raise tx_busy
// TX_WAIT  | waiting for the response byte to finish
module uart_bridge_responder
  import uart_bridge_pkg::*;
#(
  parameter int ADDR_BYTES     = 2,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 52080
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic [7:0]              i_rx_data,
  input  logic                    i_rx_ready,
  output logic                    o_rx_ready_clr,
  output logic [7:0]              o_tx_data,
  output logic                    o_tx_en,
  input  logic                    i_tx_busy,
  output logic [8*ADDR_BYTES-1:0] o_m_addr,
  output logic [DATA_WIDTH-1:0]   o_m_wdata,
  output logic                    o_m_wr,
  output logic                    o_m_valid,
  input  logic                    i_m_ready,
  input  logic [DATA_WIDTH-1:0]   i_m_rdata,
  input  logic                    i_m_rvalid,
  output logic                    o_frame_err,
  output logic                    o_busy
);

  localparam int ADDR_W = 8 * ADDR_BYTES;
  localparam int CNT_W  = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_is_wr;
  logic [CNT_W-1:0]      r_cnt;
  logic [7:0]            r_resp;

  logic       w_fetch_en;
  logic       w_byte_valid;
  logic [7:0] w_byte;
  logic       w_ferr;
  logic       w_tx_en;
  logic       w_tmo_hit;

  uart_rx_fetch u_fetch (
    .i_clk          (i_clk),
    .i_rstn         (i_rstn),
    .i_en           (w_fetch_en),
    .i_rx_ready     (i_rx_ready),
    .i_rx_data      (i_rx_data),
    .o_rx_ready_clr (o_rx_ready_clr),
    .o_byte_valid   (w_byte_valid),
    .o_byte         (w_byte)
  );

  assign w_fetch_en = (r_state == IDLE) || (r_state == ADDR) || (r_state == DATA);

`ifdef UART_BRIDGE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo;
  logic             w_in_frame;

  assign w_in_frame = (r_state == ADDR) || (r_state == DATA);
  // Fires on the cycle the idle count would reach TIMEOUT_CYCLES.
  assign w_tmo_hit  = w_in_frame && !w_byte_valid && (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rstn)                                       r_tmo <= '0;
    else if (w_in_frame && !w_byte_valid && !w_tmo_hit) r_tmo <= r_tmo + 1'b1;
    else                                               r_tmo <= '0;
  end
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
  assign w_tmo_hit    = 1'b0;
`endif

  always_comb begin
    w_next  = r_state;
    w_ferr  = 1'b0;
    w_tx_en = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_byte_valid) begin
          if (is_cmd(w_byte)) w_next = ADDR;
          else                w_ferr = 1'b1;
        end
      end
      ADDR: begin
        if (w_byte_valid && (r_cnt == CNT_W'(ADDR_BYTES - 1)))
          w_next = r_is_wr ? DATA : BUS_REQ;
      end
      DATA:     if (w_byte_valid) w_next = BUS_REQ;
      BUS_REQ:  if (i_m_ready) w_next = r_is_wr ? TX_RESP : RD_WAIT;
      RD_WAIT:  if (i_m_rvalid) w_next = TX_RESP;
      TX_RESP: begin
        if (!i_tx_busy) begin
          w_tx_en = 1'b1;
          w_next  = TX_GUARD;
        end
      end
      TX_GUARD: w_next = TX_WAIT;
      TX_WAIT:  if (!i_tx_busy) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
    if (w_tmo_hit) begin
      w_ferr = 1'b1;
      w_next = IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_is_wr <= 1'b0;
      r_cnt   <= '0;
      r_resp  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (w_byte_valid && is_cmd(w_byte)) begin
            r_is_wr <= (w_byte == CMD_WRITE);
            r_cnt   <= '0;
          end
        end
        ADDR: begin
          if (w_byte_valid) begin
            r_addr <= (r_addr << 8) | ADDR_W'(w_byte);
            r_cnt  <= r_cnt + 1'b1;
          end
        end
        DATA:    if (w_byte_valid) r_wdata <= DATA_WIDTH'(w_byte);
        BUS_REQ: if (i_m_ready && r_is_wr) r_resp <= RESP_ACK;
        RD_WAIT: if (i_m_rvalid) r_resp <= 8'(i_m_rdata);
        default: ;
      endcase
    end
  end

  // Pulses are gated by rstn so nothing fires while reset is asserted.
  assign o_tx_en     = w_tx_en && i_rstn;
  assign o_frame_err = w_ferr && i_rstn;
  assign o_tx_data   = r_resp;
  assign o_m_valid   = (r_state == BUS_REQ);
  assign o_m_addr    = r_addr;
  assign o_m_wdata   = r_wdata;
  assign o_m_wr      = r_is_wr;
  assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_bridge_responder.sv
// Directed bench for uart_bridge_responder with bus/response scoreboards.
module tb_uart_bridge_responder;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        rx_ready_clr;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic        tx_busy;
  logic [15:0] m_addr;
  logic [7:0]  m_wdata;
  logic        m_wr;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_rdata;
  logic        m_rvalid;
  logic        frame_err;
  logic        busy;

  always #5 clk = ~clk;

  uart_bridge_responder dut (
    .i_clk          (clk),
    .i_rstn         (rstn),
    .i_rx_data      (rx_data),
    .i_rx_ready     (rx_ready),
    .o_rx_ready_clr (rx_ready_clr),
    .o_tx_data      (tx_data),
    .o_tx_en        (tx_en),
    .i_tx_busy      (tx_busy),
    .o_m_addr       (m_addr),
    .o_m_wdata      (m_wdata),
    .o_m_wr         (m_wr),
    .o_m_valid      (m_valid),
    .i_m_ready      (m_ready),
    .i_m_rdata      (m_rdata),
    .i_m_rvalid     (m_rvalid),
    .o_frame_err    (frame_err),
    .o_busy         (busy)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        wr;
  } bus_t;

  bus_t       exp_bus[$];
  logic [7:0] exp_tx[$];
  bus_t       eb;
  logic [7:0] et;

  int n_tests = 0;
  int n_fail  = 0;
  int mv_cnt = 0, ferr_cnt = 0, clr_cnt = 0, txen_cnt = 0;
  int cyc_no = 0, last_clr_cyc = 0, mv_start_cyc = 0;
  logic mv_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc_no++;

  always @(negedge clk) begin
    if (m_valid) mv_cnt++;
    if (m_valid && !mv_prev) mv_start_cyc = cyc_no;
    mv_prev = m_valid;
    if (frame_err) ferr_cnt++;
    if (rx_ready_clr) begin
      clr_cnt++;
      last_clr_cyc = cyc_no;
    end
    if (m_valid && m_ready) begin
      chk("bus_expected", 32'(exp_bus.size() > 0), 1);
      if (exp_bus.size() > 0) begin
        eb = exp_bus.pop_front();
        chk("bus_addr", 32'(m_addr), 32'(eb.addr));
        chk("bus_wr", 32'(m_wr), 32'(eb.wr));
        if (eb.wr) chk("bus_wdata", 32'(m_wdata), 32'(eb.wdata));
      end
    end
    if (tx_en) begin
      txen_cnt++;
      chk("tx_expected", 32'(exp_tx.size() > 0), 1);
      if (exp_tx.size() > 0) begin
        et = exp_tx.pop_front();
        chk("tx_data", 32'(tx_data), 32'(et));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Receiver model: ready held until cleared, dropped one cycle after the clear.
  task automatic send_byte(input logic [7:0] b);
    logic got;
    got = 1'b0;
    rx_data  = b;
    rx_ready = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (rx_ready_clr) got = 1'b1;
    end
    chk("byte_consumed", 32'(got), 1);
    if (got) begin
      step(1);
      @(negedge clk);
      chk("fetch_guard", 32'(rx_ready_clr), 0);
      step(1);
    end
    rx_ready = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("return_idle", 32'(busy), 0);
    step(1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_m_valid"}, 32'(m_valid), 0);
    chk({tag, "_m_addr"}, 32'(m_addr), 0);
    chk({tag, "_m_wdata"}, 32'(m_wdata), 0);
    chk({tag, "_m_wr"}, 32'(m_wr), 0);
    chk({tag, "_tx_data"}, 32'(tx_data), 0);
    chk({tag, "_tx_en"}, 32'(tx_en), 0);
    chk({tag, "_frame_err"}, 32'(frame_err), 0);
    chk({tag, "_clr"}, 32'(rx_ready_clr), 0);
  endtask

  initial begin
    rstn = 1'b0; rx_data = 8'h00; rx_ready = 1'b0; tx_busy = 1'b0;
    m_ready = 1'b0; m_rdata = 8'h00; m_rvalid = 1'b0;
    step(3);
    @(negedge clk);
    check_zero("reset");
    step(1);
    rstn = 1'b1;
    step(1);

    // 1: write 57 12 34 AB with m_ready held high
    m_ready = 1'b1;
    mv_cnt = 0;
    exp_bus.push_back('{addr: 16'h1234, wdata: 8'hAB, wr: 1'b1});
    exp_tx.push_back(8'h06);
    send_byte(8'h57); send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB);
    wait_idle();
    chk("t1_mvalid_cycles", 32'(mv_cnt), 1);
    chk("t1_latency", 32'(mv_start_cyc - last_clr_cyc), 1);

    // 2: read 52 00 10, ready after 3 cycles, rvalid 2 cycles after handshake
    m_ready = 1'b0;
    mv_cnt = 0;
    exp_bus.push_back('{addr: 16'h0010, wdata: 8'h00, wr: 1'b0});
    exp_tx.push_back(8'h5C);
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h10);
    m_rvalid = 1'b1; m_rdata = 8'hEE;
    step(1);
    m_rvalid = 1'b0; m_ready = 1'b1;
    step(1);
    m_ready = 1'b0;
    step(1);
    m_rvalid = 1'b1; m_rdata = 8'h5C;
    step(1);
    m_rvalid = 1'b0;
    wait_idle();
    chk("t2_mvalid_cycles", 32'(mv_cnt), 3);

    // 3: bad byte in IDLE, then a normal write
    m_ready = 1'b1;
    ferr_cnt = 0; mv_cnt = 0;
    send_byte(8'hFF);
    chk("t3_ferr_pulses", 32'(ferr_cnt), 1);
    chk("t3_no_mvalid", 32'(mv_cnt), 0);
    chk("t3_idle", 32'(busy), 0);
    exp_bus.push_back('{addr: 16'h0001, wdata: 8'h02, wr: 1'b1});
    exp_tx.push_back(8'h06);
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h01); send_byte(8'h02);
    wait_idle();
    chk("t3_ferr_after", 32'(ferr_cnt), 1);

    // 4: transmitter busy at TX_RESP, next frame pending meanwhile
    tx_busy = 1'b1;
    txen_cnt = 0;
    exp_bus.push_back('{addr: 16'h0005, wdata: 8'h77, wr: 1'b1});
    exp_tx.push_back(8'h06);
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h05); send_byte(8'h77);
    clr_cnt = 0;
    rx_data = 8'h52; rx_ready = 1'b1;
    step(20);
    chk("t4_no_tx_en_busy", 32'(txen_cnt), 0);
    chk("t4_pending_busy", 32'(clr_cnt), 0);
    tx_busy = 1'b0;
    for (int i = 0; i < 20 && txen_cnt == 0; i++) @(negedge clk);
    chk("t4_tx_en_after", 32'(txen_cnt), 1);
    step(1);
    tx_busy = 1'b1;
    step(5);
    chk("t4_pending_txwait", 32'(clr_cnt), 0);
    tx_busy = 1'b0;
    exp_bus.push_back('{addr: 16'h0030, wdata: 8'h00, wr: 1'b0});
    exp_tx.push_back(8'hA5);
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h30);
    m_rvalid = 1'b1; m_rdata = 8'hA5;
    step(1);
    m_rvalid = 1'b0;
    wait_idle();

    // 5: reset mid-frame, then a read of 0x0020
    m_ready = 1'b0;
    send_byte(8'h57); send_byte(8'h12);
    rstn = 1'b0;
    step(1);
    rstn = 1'b1;
    @(negedge clk);
    check_zero("t5");
    step(1);
    m_ready = 1'b1;
    exp_bus.push_back('{addr: 16'h0020, wdata: 8'h00, wr: 1'b0});
    exp_tx.push_back(8'h3C);
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h20);
    m_rvalid = 1'b1; m_rdata = 8'h3C;
    step(1);
    m_rvalid = 1'b0;
    wait_idle();

    // 6: partial frame then silence
    ferr_cnt = 0;
    send_byte(8'h57); send_byte(8'h12);
`ifdef UART_BRIDGE_TIMEOUT_EN
    for (int i = 0; i < 52200 && ferr_cnt == 0; i++) @(negedge clk);
    chk("t6_timeout_ferr", 32'(ferr_cnt), 1);
    step(1);
    @(negedge clk);
    chk("t6_timeout_idle", 32'(busy), 0);
    step(1);
`else
    step(300);
    @(negedge clk);
    chk("t6_wait_busy", 32'(busy), 1);
    chk("t6_no_ferr", 32'(ferr_cnt), 0);
    step(1);
    rstn = 1'b0;
    step(1);
    rstn = 1'b1;
    @(negedge clk);
    chk("t6_reset_idle", 32'(busy), 0);
    step(1);
`endif

    chk("bus_queue_empty", 32'(exp_bus.size()), 0);
    chk("tx_queue_empty", 32'(exp_tx.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
